// File: rtl/valve_latch_bank.sv
// Multi-channel valve latch: masked shadow register, commit to target, per-channel dwell FSM on q.
// Optional force-close input estop is compiled in when VALVE_ESTOP_EN is defined.
module valve_latch_bank #(
  parameter int CHANNELS    = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int HOLD_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
`ifdef VALVE_ESTOP_EN
  input  logic                estop,
`endif
  input  logic                wr_en,
  input  logic [CHANNELS-1:0] wr_data,
  input  logic [CHANNELS-1:0] wr_mask,
  input  logic                commit,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] pending,
  output logic                busy,
  output logic                commit_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_PEND = 2'd2
  } ch_state_e;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] CNT_ZERO  = {HOLD_W{1'b0}};

  logic [CHANNELS-1:0] shadow_r, shadow_s;
  logic [CHANNELS-1:0] target_r, target_s;
  logic [CHANNELS-1:0] q_r, q_s;
  logic [CHANNELS-1:0] pending_r, pending_s;
  logic                ack_r, ack_s;
  logic                estop_s;
  ch_state_e           state_r [CHANNELS];
  ch_state_e           state_s [CHANNELS];
  logic [HOLD_W-1:0]   cnt_r   [CHANNELS];
  logic [HOLD_W-1:0]   cnt_s   [CHANNELS];

  function automatic logic [HOLD_W-1:0] dec_sat(input logic [HOLD_W-1:0] v);
    if (v == CNT_ZERO) begin
      return CNT_ZERO;
    end else begin
      return v - {{(HOLD_W-1){1'b0}}, 1'b1};
    end
  endfunction

`ifdef VALVE_ESTOP_EN
  assign estop_s = estop;
`else
  assign estop_s = 1'b0;
`endif

  // Shadow write-through and commit transfer into the target register.
  always_comb begin
    shadow_s = shadow_r;
    target_s = target_r;
    ack_s    = 1'b0;
    if (wr_en) begin
      shadow_s = (shadow_r & ~wr_mask) | (wr_data & wr_mask);
    end else begin
      shadow_s = shadow_r;
    end
    if (estop_s) begin
      target_s = {CHANNELS{1'b0}};
      ack_s    = 1'b0;
    end else if (commit) begin
      target_s = shadow_s;
      ack_s    = 1'b1;
    end else begin
      target_s = target_r;
      ack_s    = 1'b0;
    end
  end

  // Per-channel dwell FSM; HOLD/PEND compare against the incoming target so pending tracks commits.
  always_comb begin
    q_s       = q_r;
    pending_s = pending_r;
    for (int i = 0; i < CHANNELS; i++) begin
      state_s[i] = state_r[i];
      cnt_s[i]   = cnt_r[i];
      if (estop_s) begin
        state_s[i]   = ST_IDLE;
        cnt_s[i]     = CNT_ZERO;
        q_s[i]       = 1'b0;
        pending_s[i] = 1'b0;
      end else begin
        case (state_r[i])
          ST_IDLE: begin
            pending_s[i] = 1'b0;
            if (target_r[i] != q_r[i]) begin
              q_s[i]     = target_r[i];
              cnt_s[i]   = HOLD_LOAD;
              state_s[i] = ST_HOLD;
            end else begin
              cnt_s[i]   = CNT_ZERO;
              state_s[i] = ST_IDLE;
            end
          end
          ST_HOLD: begin
            if (target_s[i] != q_r[i]) begin
              pending_s[i] = 1'b1;
              cnt_s[i]     = dec_sat(cnt_r[i]);
              state_s[i]   = ST_PEND;
            end else if (cnt_r[i] == CNT_ZERO) begin
              pending_s[i] = 1'b0;
              cnt_s[i]     = CNT_ZERO;
              state_s[i]   = ST_IDLE;
            end else begin
              pending_s[i] = 1'b0;
              cnt_s[i]     = dec_sat(cnt_r[i]);
              state_s[i]   = ST_HOLD;
            end
          end
          ST_PEND: begin
            if (target_s[i] == q_r[i]) begin
              pending_s[i] = 1'b0;
              cnt_s[i]     = dec_sat(cnt_r[i]);
              state_s[i]   = ST_HOLD;
            end else if (cnt_r[i] == CNT_ZERO) begin
              q_s[i]       = target_s[i];
              pending_s[i] = 1'b0;
              cnt_s[i]     = HOLD_LOAD;
              state_s[i]   = ST_HOLD;
            end else begin
              pending_s[i] = 1'b1;
              cnt_s[i]     = dec_sat(cnt_r[i]);
              state_s[i]   = ST_PEND;
            end
          end
          default: begin
            q_s[i]       = 1'b0;
            pending_s[i] = 1'b0;
            cnt_s[i]     = CNT_ZERO;
            state_s[i]   = ST_IDLE;
          end
        endcase
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r  <= {CHANNELS{1'b0}};
      target_r  <= {CHANNELS{1'b0}};
      q_r       <= {CHANNELS{1'b0}};
      pending_r <= {CHANNELS{1'b0}};
      ack_r     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i] <= ST_IDLE;
        cnt_r[i]   <= CNT_ZERO;
      end
    end else begin
      shadow_r  <= shadow_s;
      target_r  <= target_s;
      q_r       <= q_s;
      pending_r <= pending_s;
      ack_r     <= ack_s;
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i] <= state_s[i];
        cnt_r[i]   <= cnt_s[i];
      end
    end
  end

  assign q          = q_r;
  assign pending    = pending_r;
  assign busy       = |pending_r;
  assign commit_ack = ack_r;

endmodule
